// File: rtl/fix_div_if.sv
// Operand/result handshake bundle for the fixed-point divider.
// master = producer/consumer side, slave = divider.
interface fix_div_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_ovf;
    logic             out_dz;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_a, in_b, in_valid, out_ready,
        input  in_ready, out_q, out_ovf, out_dz, out_valid
    );

    modport slave (
        input  in_a, in_b, in_valid, out_ready,
        output in_ready, out_q, out_ovf, out_dz, out_valid
    );
endinterface

// File: rtl/fix_div.sv
// Sequential signed Q-format divider: restoring division on magnitudes,
// one quotient bit per cycle, sign and saturation applied at the end.
module fix_div #(
    parameter int WIDTH       = 16,
    parameter int POINT_WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    fix_div_if.slave bus
);
    localparam int ITER = WIDTH + POINT_WIDTH;
    localparam int CW   = $clog2(ITER + 1);

    // Largest quotient magnitudes that still fit the signed result.
    localparam logic [ITER-1:0] NEG_MAG = ITER'(1) << (WIDTH - 1);
    localparam logic [ITER-1:0] POS_MAX = NEG_MAG - ITER'(1);

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [ITER-1:0]  n;
    logic [ITER-1:0]  q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             a_neg;
    logic             a_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_sub;
    logic             take;
    logic [WIDTH-1:0] res_q;
    logic             res_ovf;
    logic             res_dz;

    // Two's-complement negate of the most negative value yields 2^(WIDTH-1),
    // which is exactly right when read as unsigned.
    assign a_mag = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign b_mag = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;

    assign r_sh  = {r, n[ITER-1]};
    assign r_sub = r_sh - {1'b0, d};
    assign take  = (r_sh >= {1'b0, d});

    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        res_dz  = (d == '0);
        if (res_dz) begin
            if (a_zero)     res_q = '0;
            else if (a_neg) res_q = SAT_NEG;
            else            res_q = SAT_POS;
        end else if (!sign) begin
            if (q > POS_MAX) begin
                res_q   = SAT_POS;
                res_ovf = 1'b1;
            end else begin
                res_q = q[WIDTH-1:0];
            end
        end else begin
            if (q > NEG_MAG) begin
                res_q   = SAT_NEG;
                res_ovf = 1'b1;
            end else begin
                res_q = -q[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_q     <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_dz    <= 1'b0;
            n             <= '0;
            q             <= '0;
            d             <= '0;
            r             <= '0;
            cnt           <= '0;
            sign          <= 1'b0;
            a_neg         <= 1'b0;
            a_zero        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign         <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
                        a_neg        <= bus.in_a[WIDTH-1];
                        a_zero       <= (bus.in_a == '0);
                        n            <= ITER'(a_mag) << POINT_WIDTH;
                        d            <= b_mag;
                        r            <= '0;
                        q            <= '0;
                        cnt          <= '0;
                        state        <= CALC;
                        bus.in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    // ITER shift/subtract steps, then one cycle to form the result.
                    if (cnt == CW'(ITER)) begin
                        bus.out_q     <= res_q;
                        bus.out_ovf   <= res_ovf;
                        bus.out_dz    <= res_dz;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        r   <= take ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
                        q   <= {q[ITER-2:0], take};
                        n   <= n << 1;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_div.sv
// Bench for fix_div: directed plan vectors, randomized ops against an
// integer-arithmetic reference, backpressure and mid-operation reset.
module tb_fix_div;
    localparam int W   = 16;
    localparam int P   = 8;
    localparam int LAT = W + P + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fix_div_if #(.WIDTH(W)) bus ();
    fix_div #(.WIDTH(W), .POINT_WIDTH(P)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference: exact quotient a*2^P/b truncated toward zero, then clamped.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic ovf, output logic dz);
        longint sa, sb, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0;
        dz  = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            if (sa > 0)      q = 16'h7FFF;
            else if (sa < 0) q = 16'h8000;
            else             q = 16'h0000;
        end else begin
            res = (sa * (longint'(1) << P)) / sb;
            if (res > 32767) begin
                q = 16'h7FFF; ovf = 1'b1;
            end else if (res < -32768) begin
                q = 16'h8000; ovf = 1'b1;
            end else begin
                q = res[W-1:0];
            end
        end
    endfunction

    // Runs one operation end to end; lat = cycles from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic ovf, output logic dz, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a = W'($urandom); bus.in_b = W'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) lat = -1;
        q = bus.out_q; ovf = bus.out_ovf; dz = bus.out_dz;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        tests++;
        if ({bus.out_q, bus.out_ovf, bus.out_dz} !== 18'h0)
            begin fails++; $display("FAIL reset_outputs got q=%h ovf=%b dz=%b exp 0/0/0", bus.out_q, bus.out_ovf, bus.out_dz); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [11] = '{16'h0300, 16'hFF00, 16'hFF00, 16'h7F00, 16'h8000, 16'h8000,
                                  16'hFE00, 16'h0100, 16'h0000, 16'h0000, 16'h0001};
        logic [W-1:0] vb [11] = '{16'h0200, 16'h0300, 16'hFD00, 16'h0080, 16'hFF00, 16'h0100,
                                  16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF};
        logic [W-1:0] eq [11] = '{16'h0180, 16'hFFAB, 16'h0055, 16'h7FFF, 16'h7FFF, 16'h8000,
                                  16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'hFF00};
        logic         eo [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic         ed [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        logic [W-1:0] q;
        logic         ovf, dz;
        int           lat;
        for (int i = 0; i < 11; i++) begin
            do_op(va[i], vb[i], q, ovf, dz, lat);
            tests++;
            if ({q, ovf, dz} !== {eq[i], eo[i], ed[i]})
                begin fails++; $display("FAIL directed[%0d] %h/%h got q=%h ovf=%b dz=%b exp q=%h ovf=%b dz=%b",
                                        i, va[i], vb[i], q, ovf, dz, eq[i], eo[i], ed[i]); end
            tests++;
            if (lat !== LAT) begin fails++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, eq;
        logic         ovf, dz, eo, ed;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 16'h8000;
                2: b = W'($signed(int'($urandom_range(0, 6)) - 3));
                3: b = 16'h8000;
                default: ;
            endcase
            ref_div(a, b, eq, eo, ed);
            do_op(a, b, q, ovf, dz, lat);
            tests++;
            if ({q, ovf, dz, lat} !== {eq, eo, ed, LAT})
                begin fails++; $display("FAIL random[%0d] %h/%h got q=%h ovf=%b dz=%b lat=%0d exp q=%h ovf=%b dz=%b lat=%0d",
                                        i, a, b, q, ovf, dz, lat, eq, eo, ed, LAT); end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        bus.in_a = 16'h0500; bus.in_b = 16'h0200; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        for (int c = 0; c < 10; c++) begin
            tests++;
            if ({bus.out_q, bus.out_ovf, bus.out_dz, bus.out_valid, bus.in_ready} !== {16'h0280, 1'b0, 1'b0, 1'b1, 1'b0})
                begin fails++; $display("FAIL hold[%0d] got q=%h ovf=%b dz=%b vld=%b rdy=%b exp q=0280 ovf=0 dz=0 vld=1 rdy=0",
                                        c, bus.out_q, bus.out_ovf, bus.out_dz, bus.out_valid, bus.in_ready); end
            bus.in_valid = (c == 2);
            bus.in_a = 16'h0100; bus.in_b = 16'h0100;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            begin fails++; $display("FAIL release got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
        tests++;
        if (bus.out_q !== 16'h0280) begin fails++; $display("FAIL post_hold_q got=%h exp=0280", bus.out_q); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q;
        logic         ovf, dz;
        int           lat;
        do_op(16'h0C00, 16'h0400, q, ovf, dz, lat);
        tests++;
        if ({q, ovf, dz} !== {16'h0300, 1'b0, 1'b0})
            begin fails++; $display("FAIL back_to_back got q=%h ovf=%b dz=%b exp q=0300 ovf=0 dz=0", q, ovf, dz); end
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL back_to_back_lat got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q;
        logic         ovf, dz;
        int           lat;
        bus.in_a = 16'h7000; bus.in_b = 16'h0300; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_q, bus.out_ovf, bus.out_dz} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            begin fails++; $display("FAIL mid_reset got rdy=%b vld=%b q=%h ovf=%b dz=%b exp 1/0/0000/0/0",
                                    bus.in_ready, bus.out_valid, bus.out_q, bus.out_ovf, bus.out_dz); end
        do_op(16'h0100, 16'h0400, q, ovf, dz, lat);
        tests++;
        if ({q, ovf, dz, lat} !== {16'h0040, 1'b0, 1'b0, LAT})
            begin fails++; $display("FAIL after_reset got q=%h ovf=%b dz=%b lat=%0d exp q=0040 ovf=0 dz=0 lat=%0d",
                                    q, ovf, dz, lat, LAT); end
    endtask

    initial begin
        bus.in_a = '0; bus.in_b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
